// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder controller
`timescale 1ns/10ps
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - requester-side command/result bundle of the serial adder
`timescale 1ns/10ps
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b, cin,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b, cin,
    output busy, done, result, cout, ovf
  );

endinterface

// File: rtl/addbit.sv
// rtl/addbit.sv - gate-level 1-bit full adder cell
`timescale 1ns/10ps
module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic t_ab;
  logic g_ab;
  logic p_c;

  xor x_ab  (t_ab, a, b);
  xor x_sum (sum, t_ab, ci);
  and a_g   (g_ab, a, b);
  and a_p   (p_c, t_ab, ci);
  or  o_co  (co, g_ab, p_c);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - sequences one addbit cell over WIDTH cycles, LSB first
`timescale 1ns/10ps
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             sum;
  logic             co;
  logic [WIDTH-1:0] sh_next;

  addbit u_add (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .ci  (carry_q),
    .sum (sum),
    .co  (co)
  );

  // Partial result shifts right; the freshly computed bit enters at the MSB.
  assign sh_next = {sum, sh_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sh_d     = sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = sh_next[WIDTH-1:1];
        carry_d = co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          result_d = sh_next;
          cout_d   = co;
          ovf_d    = carry_q ^ co;
          state_d  = ST_DONE;
        end
      end
      default: begin
        // Subtraction is A + ~B + 1, so the inverted B and forced carry do the work.
        if (bus.start) begin
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl with an arithmetic reference model
`timescale 1ns/10ps
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  longint cyc = 0;
  exp_t exp_q[$];
  logic [W-1:0] last_res = '0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    longint ua, ub, sa, sb, ur, sr;
    exp_t e;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (s) begin
      ur   = ua - ub;
      sr   = sa - sb;
      e.co = (ua >= ub);
    end else begin
      ur   = ua + ub + longint'(ci);
      sr   = sa + sb + longint'(ci);
      e.co = (ur >= (longint'(1) << W));
    end
    e.res = ur[W-1:0];
    e.ov  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", longint'(bus.result), longint'(e.res));
        check("cout", longint'(bus.cout), longint'(e.co));
        check("ovf", longint'(bus.ovf), longint'(e.ov));
      end
    end
  end

  // Called on a negedge; start is sampled at the following posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic s, input bit push);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = ci;
    bus.sub   = s;
    bus.start = 1'b1;
    if (push) exp_q.push_back(model(a, b, ci, s));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = W'($urandom);
    bus.op_b  = W'($urandom);
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic wait_done(input string name, output int k);
    k = 0;
    while (!bus.done && k < 3 * W) begin
      @(negedge clk);
      k++;
    end
    if (!bus.done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic s);
    int k;
    start_op(a, b, ci, s, 1'b1);
    check({name, "_busy"}, longint'(bus.busy), 1);
    check({name, "_hold"}, longint'(bus.result), longint'(last_res));
    wait_done(name, k);
    check({name, "_latency"}, longint'(k), longint'(W));
    last_res = model(a, b, ci, s).res;
  endtask

  initial begin
    int k;
    longint t0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_result", longint'(bus.result), 0);
    check("rst_cout", longint'(bus.cout), 0);
    check("rst_ovf", longint'(bus.ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add5a33", 8'h5A, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    run_op("addff01", 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    run_op("addff00c", 8'hFF, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    run_op("sub1020", 8'h10, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    run_op("sub8001", 8'h80, 8'h01, 1'b1, 1'b1);
    @(negedge clk);

    // Start during RUN must be ignored.
    start_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.op_a  = 8'h77;
    bus.op_b  = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("midrun_busy", longint'(bus.busy), 1);
    wait_done("midrun", k);
    last_res = 8'h03;
    repeat (W + 3) @(negedge clk);
    check("midrun_idle_busy", longint'(bus.busy), 0);

    // Back-to-back: second start issued in the DONE cycle.
    run_op("b2b_first", 8'h01, 8'h01, 1'b0, 1'b0);
    t0 = cyc;
    run_op("b2b_second", 8'h0F, 8'h01, 1'b0, 1'b0);
    check("b2b_spacing", cyc - t0, longint'(W + 1));
    @(negedge clk);

    // Reset in the middle of an operation.
    start_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", longint'(bus.busy), 0);
    check("abort_done", longint'(bus.done), 0);
    check("abort_result", longint'(bus.result), 0);
    check("abort_cout", longint'(bus.cout), 0);
    check("abort_ovf", longint'(bus.ovf), 0);
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("abort_queue", longint'(exp_q.size()), 0);
    run_op("after_abort", 8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end

    repeat (W + 3) @(negedge clk);
    check("final_queue", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder/subtractor controller. It sequences a single gate-level `addbit` full-adder cell over `WIDTH` clock cycles to add or subtract two `WIDTH`-bit operands, LSB first. It holds the carry between cycles, assembles the result and flags carry and overflow. It sits between a requester issuing start/operand commands and the shared 1-bit adder datapath.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request a new operation; sampled on a rising edge.
- `sub` in 1: 0 = add, 1 = subtract (`op_a - op_b`); latched with `start`.
- `op_a` in WIDTH: operand A; latched with `start`.
- `op_b` in WIDTH: operand B; latched with `start`.
- `cin` in 1: carry-in for add; ignored when `sub`=1.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; result is valid.
- `result` out WIDTH: sum/difference; held until the next accepted `start`.
- `cout` out 1: carry out of the MSB. In subtract mode this is the not-borrow flag.
- `ovf` out 1: two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 → RUN.
  - Latch `op_a` into shift register A.
  - Latch `op_b` into shift register B, inverted when `sub`=1.
  - Carry register = `sub ? 1 : cin`.
  - Bit counter = 0.
- **RUN** (one bit per cycle)
  - `addbit` inputs: a = A[0], b = B[0], ci = carry register.
  - Each edge:
    - Shift `sum` into the MSB of the result shift register; result shifts right.
    - Carry register ← `co`.
    - A and B shift right.
    - Counter increments.
  - At the edge where counter = WIDTH-1:
    - Capture `ovf` = carry-in of this bit XOR `co`.
    - Capture `cout` = `co`.
    - Go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `start`=1 in DONE is accepted: same latch actions as IDLE, next state RUN. This gives back-to-back operation.
  - Otherwise → IDLE.
- `start` in RUN is ignored. There is no queueing, and the operands are not re-latched.
- `result`, `cout` and `ovf` change only at the final RUN edge. They hold until the next operation completes.
- Reset values, applied asynchronously:
  - State = IDLE.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0.
  - Carry register, counter, A and B = 0.
- Reset asserted mid-RUN aborts the operation. No `done` is produced, and `result` returns to 0.

## Timing
- `start` sampled at edge E0.
- Bit i is processed in the cycle before edge E(i+1), for i = 0..WIDTH-1.
- `busy`=1 from after E0 until after E(WIDTH).
- `done`=1 in the cycle after E(WIDTH).
- Start-to-done latency: WIDTH cycles. Back-to-back throughput: one operation per WIDTH+1 cycles.
- The `addbit` path (two XOR levels plus AND-OR) is purely combinational within one cycle.
- Timescale is 1ns / 10ps.
- With annotated module input path delays up to 2.5 ns, the clock period must be ≥ 20 ns. The bench uses a 20 ns clock.

## Structure
- Shared package `serial_add_pkg` holds:
  - FSM state typedef (IDLE/RUN/DONE, 2-bit encoding).
  - `WIDTH` default constant.
- One sub-module, the existing gate-level `addbit`, instantiated once as `u_add`.
- The controller is kept separate from `addbit` so per-port delays can still be set on `u_add` inputs from the bench.

## Test plan
1. Add, WIDTH=8: `op_a`=0x5A, `op_b`=0x33, `cin`=0 → `result`=0x8D, `cout`=0, `ovf`=1. `done` appears exactly 8 cycles after the start edge.
2. Carry wrap: `op_a`=0xFF, `op_b`=0x01, `cin`=0 → `result`=0x00, `cout`=1, `ovf`=0. With `cin`=1 and `op_b`=0x00 → `result`=0x00, `cout`=1.
3. Subtract:
   - `op_a`=0x10, `op_b`=0x20, `sub`=1 → `result`=0xF0, `cout`=0, `ovf`=0.
   - `op_a`=0x80, `op_b`=0x01, `sub`=1 → `result`=0x7F, `cout`=1, `ovf`=1.
4. Start during RUN: pulse `start` with new operands 3 cycles into an add of 0x01+0x02 → `result`=0x03. Only one `done` pulse occurs, and `busy` is unchanged.
5. Back-to-back: assert `start` in the DONE cycle (0x0F+0x01 after 0x01+0x01):
   - First `result`=0x02.
   - Second `result`=0x10.
   - Two `done` pulses, 9 cycles apart.
6. Reset mid-RUN: deassert `rst_n` 4 cycles into 0x5A+0x33:
   - All outputs = 0 immediately.
   - No `done` pulse.
   - A following 0x01+0x01 yields 0x02.
